multicycle_sequencer: RTL and testbench

//  - Multi-cycle FSM that sequences the rv32i datapath: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
//  - Consumes the decoded control fields (mem_op, regfile_src, inst_valid).
//  - Drives register-enable strobes and the single shared memory port handshake.
//  - Maintains retired-instruction and cycle counters.
//  - Raises a sticky trap on an illegal instruction or on a bus timeout.

---
 rtl/multicycle_sequencer_pkg.sv | 40 ++++
 rtl/multicycle_sequencer_mem_wait_timer.sv | 41 ++++
 rtl/multicycle_sequencer.sv | 140 ++++++++++++++
 tb/tb_multicycle_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer_pkg
// Shared encodings for the rv32i multi-cycle sequencer: FSM state codes, trap
// causes, and the mem_op / regfile_src codes produced by the control unit.
// No ports.
// -----------------------------------------------------------------------------
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_BUS     = 2'd2
    } trap_e;

    localparam logic [1:0] MEM_OP_NONE  = 2'd0;
    localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
    localparam logic [1:0] MEM_OP_STORE = 2'd2;

    localparam logic [2:0] REG_SRC_NONE = 3'd0;
    localparam logic [2:0] REG_SRC_ALU  = 3'd1;
    localparam logic [2:0] REG_SRC_MEM  = 3'd2;
    localparam logic [2:0] REG_SRC_PC4  = 3'd3;
    localparam logic [2:0] REG_SRC_IMM  = 3'd4;

    // States that own the shared memory port.
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEM);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive cycles a memory transaction waits for mem_ready and flags
// expiry on the LIMIT-th waiting cycle. Only built with MEM_TIMEOUT_EN.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous reset, active-high
//   active_i   a memory transaction is outstanding this cycle
//   ready_i    memory completes the transaction this cycle
//   expired_o  this cycle is the LIMIT-th wait cycle and ready_i is low
// -----------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
module mem_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    input  logic ready_i,
    output logic expired_o
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Clearing whenever idle means the count restarts on every entry to a
    // memory state, since those states are never back-to-back.
    always_comb begin
        cnt_d = '0;
        if (active_i && !ready_i) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // A completion in the limit cycle is not a timeout.
    assign expired_o = active_i && !ready_i && (cnt_q == W'(LIMIT - 1));
endmodule
`endif

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
// Multi-cycle FSM sequencing the rv32i datapath FETCH->DECODE->EXEC->[MEM]->WB,
// driving register strobes and the shared memory port, counting cycles and
// retired instructions, and raising a sticky trap.
// Optional feature macro: MEM_TIMEOUT_EN (bus wait timeout -> TRAP_BUS).
// Ports:
//   clk_i           system clock, rising edge
//   rst_i           synchronous reset, active-high
//   mem_op_i        MEM_OP_* from control unit
//   regfile_src_i   REG_SRC_* from control unit (NONE = no rd write)
//   inst_valid_i    decoded instruction is legal
//   mem_ready_i     memory completes current transaction this cycle
//   mem_req_o       memory transaction request
//   mem_we_o        1 = store, 0 = read (meaningful while mem_req_o)
//   mem_addr_sel_o  0 = PC, 1 = ALU result
//   ir_we_o         latch instruction register
//   rf_we_o         register-file write enable
//   pc_we_o         update PC
//   trap_o          sticky trap flag
//   trap_cause_o    TRAP_* cause
//   state_o         current FSM state (debug)
//   cycle_cnt_o     cycles since reset (frozen in S_TRAP)
//   instret_cnt_o   retired instructions
// -----------------------------------------------------------------------------
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       mem_op_i,
    input  logic [2:0]       regfile_src_i,
    input  logic             inst_valid_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_addr_sel_o,
    output logic             ir_we_o,
    output logic             rf_we_o,
    output logic             pc_we_o,
    output logic             trap_o,
    output logic [1:0]       trap_cause_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_cnt_o
);
    state_e           state_q;
    trap_e            cause_q;
    logic             trap_q;
    logic [1:0]       mem_op_q;
    logic [2:0]       rf_src_q;
    logic [CNT_W-1:0] cycle_q, instret_q;
    logic             timeout;

`ifdef MEM_TIMEOUT_EN
    mem_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_mem_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .active_i  (is_mem_state(state_q)),
        .ready_i   (mem_ready_i),
        .expired_o (timeout)
    );
`else
    // Waits are unbounded; the parameter stays in the interface for both builds.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_RESET;
            trap_q    <= 1'b0;
            cause_q   <= TRAP_NONE;
            mem_op_q  <= MEM_OP_NONE;
            rf_src_q  <= REG_SRC_NONE;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != S_TRAP) cycle_q <= cycle_q + CNT_W'(1);
            unique case (state_q)
                S_RESET: state_q <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready_i) state_q <= S_DECODE;
                    else if (timeout) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= TRAP_BUS;
                    end
                end
                S_DECODE: begin
                    if (!inst_valid_i) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= TRAP_ILLEGAL;
                    end else begin
                        mem_op_q <= mem_op_i;
                        rf_src_q <= regfile_src_i;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: state_q <= (mem_op_q != MEM_OP_NONE) ? S_MEM : S_WB;
                S_MEM: begin
                    if (mem_ready_i) state_q <= S_WB;
                    else if (timeout) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= TRAP_BUS;
                    end
                end
                S_WB: begin
                    instret_q <= instret_q + CNT_W'(1);
                    state_q   <= S_FETCH;
                end
                S_TRAP: state_q <= S_TRAP;
                default: state_q <= S_RESET;
            endcase
        end
    end

    // Strobes decode from the state register and latched fields; ir_we also
    // needs mem_ready so the IR captures the word in the completing cycle.
    always_comb begin
        mem_req_o      = is_mem_state(state_q);
        mem_addr_sel_o = (state_q == S_MEM);
        mem_we_o       = (state_q == S_MEM) && (mem_op_q == MEM_OP_STORE);
        ir_we_o        = (state_q == S_FETCH) && mem_ready_i;
        pc_we_o        = (state_q == S_WB);
        rf_we_o        = (state_q == S_WB) && (rf_src_q != REG_SRC_NONE)
                         && (mem_op_q != MEM_OP_STORE);
    end

    assign trap_o        = trap_q;
    assign trap_cause_o  = cause_q;
    assign state_o       = state_q;
    assign cycle_cnt_o   = cycle_q;
    assign instret_cnt_o = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  op  = MEM_OP_NONE;
    logic [2:0]  src = REG_SRC_NONE;
    logic        vld = 1'b0;
    logic        rdy = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, rf_we, pc_we, trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, instret_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.CNT_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst), .mem_op_i(op), .regfile_src_i(src),
        .inst_valid_i(vld), .mem_ready_i(rdy), .mem_req_o(mem_req),
        .mem_we_o(mem_we), .mem_addr_sel_o(mem_addr_sel), .ir_we_o(ir_we),
        .rf_we_o(rf_we), .pc_we_o(pc_we), .trap_o(trap),
        .trap_cause_o(trap_cause), .state_o(state),
        .cycle_cnt_o(cycle_cnt), .instret_cnt_o(instret_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rst high for 3 edges, then one S_RESET cycle: returns in S_FETCH.
    task automatic reset_dut();
        rst = 1'b1; op = MEM_OP_NONE; src = REG_SRC_NONE; vld = 1'b0; rdy = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    // One cycle: inputs applied during it and outputs expected during it.
    typedef struct {
        logic       rst;
        logic [1:0] op;
        logic [2:0] src;
        logic       vld;
        logic       rdy;
        logic [2:0] st;
        logic [5:0] strb;   // {req, we, sel, ir, rf, pc}
        int         ret;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic [1:0] o, logic [2:0] s, logic va,
                               logic rd, state_e st, logic [5:0] strb, int ret);
        vec_t x;
        x.rst = r; x.op = o; x.src = s; x.vld = va; x.rdy = rd;
        x.st = st; x.strb = strb; x.ret = ret;
        return x;
    endfunction

    initial begin
        // LW (3 wait cycles), SW (3 wait cycles, src=ALU still no rd write),
        // a no-rd non-mem op, an ADDI. Non-decode cycles carry junk fields
        // and inst_valid=0 to show they are ignored.
        tbl.push_back(v(1, MEM_OP_NONE,  REG_SRC_NONE, 0, 1, S_RESET,  6'b000000, 0));
        tbl.push_back(v(1, MEM_OP_LOAD,  REG_SRC_MEM,  1, 0, S_RESET,  6'b000000, 0));
        tbl.push_back(v(0, MEM_OP_NONE,  REG_SRC_NONE, 0, 1, S_RESET,  6'b000000, 0));
        tbl.push_back(v(0, MEM_OP_NONE,  REG_SRC_NONE, 0, 0, S_FETCH,  6'b100000, 0));
        tbl.push_back(v(0, MEM_OP_STORE, REG_SRC_NONE, 0, 1, S_FETCH,  6'b100100, 0));
        tbl.push_back(v(0, MEM_OP_LOAD,  REG_SRC_MEM,  1, 1, S_DECODE, 6'b000000, 0));
        tbl.push_back(v(0, MEM_OP_NONE,  REG_SRC_NONE, 0, 1, S_EXEC,   6'b000000, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(0, MEM_OP_STORE, REG_SRC_NONE, 0, 0, S_MEM, 6'b101000, 0));
        tbl.push_back(v(0, MEM_OP_STORE, REG_SRC_NONE, 0, 1, S_MEM,    6'b101000, 0));
        tbl.push_back(v(0, MEM_OP_STORE, REG_SRC_NONE, 0, 1, S_WB,     6'b000011, 0));
        tbl.push_back(v(0, MEM_OP_NONE,  REG_SRC_NONE, 0, 1, S_FETCH,  6'b100100, 1));
        tbl.push_back(v(0, MEM_OP_STORE, REG_SRC_ALU,  1, 0, S_DECODE, 6'b000000, 1));
        tbl.push_back(v(0, MEM_OP_NONE,  REG_SRC_MEM,  0, 1, S_EXEC,   6'b000000, 1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(0, MEM_OP_NONE, REG_SRC_MEM, 0, 0, S_MEM,  6'b111000, 1));
        tbl.push_back(v(0, MEM_OP_NONE,  REG_SRC_MEM,  0, 1, S_MEM,    6'b111000, 1));
        tbl.push_back(v(0, MEM_OP_LOAD,  REG_SRC_MEM,  0, 0, S_WB,     6'b000001, 1));
        tbl.push_back(v(0, MEM_OP_NONE,  REG_SRC_NONE, 0, 1, S_FETCH,  6'b100100, 2));
        tbl.push_back(v(0, MEM_OP_NONE,  REG_SRC_NONE, 1, 1, S_DECODE, 6'b000000, 2));
        tbl.push_back(v(0, MEM_OP_LOAD,  REG_SRC_ALU,  0, 1, S_EXEC,   6'b000000, 2));
        tbl.push_back(v(0, MEM_OP_LOAD,  REG_SRC_ALU,  0, 1, S_WB,     6'b000001, 2));
        tbl.push_back(v(0, MEM_OP_NONE,  REG_SRC_NONE, 0, 1, S_FETCH,  6'b100100, 3));
        tbl.push_back(v(0, MEM_OP_NONE,  REG_SRC_ALU,  1, 0, S_DECODE, 6'b000000, 3));
        tbl.push_back(v(0, MEM_OP_STORE, REG_SRC_NONE, 0, 1, S_EXEC,   6'b000000, 3));
        tbl.push_back(v(0, MEM_OP_STORE, REG_SRC_NONE, 0, 1, S_WB,     6'b000011, 3));
        tbl.push_back(v(0, MEM_OP_NONE,  REG_SRC_NONE, 0, 0, S_FETCH,  6'b100000, 4));

        // First reset edge gets the state out of X; rows 0-1 add two more.
        tick();
        foreach (tbl[i]) begin
            rst = tbl[i].rst; op = tbl[i].op; src = tbl[i].src;
            vld = tbl[i].vld; rdy = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d state", i),   {29'd0, state},   {29'd0, tbl[i].st});
            chk($sformatf("row%0d strobes", i),
                {26'd0, mem_req, mem_we, mem_addr_sel, ir_we, rf_we, pc_we},
                {26'd0, tbl[i].strb});
            chk($sformatf("row%0d trap", i),    {31'd0, trap},    32'd0);
            chk($sformatf("row%0d cycle", i),   cycle_cnt,        (i <= 2) ? 32'd0 : 32'(i - 2));
            chk($sformatf("row%0d instret", i), instret_cnt,      32'(tbl[i].ret));
            tick();
        end

        // ADDI stream with mem_ready tied high.
        reset_dut();
        chk("rel2 state", {29'd0, state}, {29'd0, S_FETCH});
        chk("rel2 mem_req", {31'd0, mem_req}, 32'd1);
        op = MEM_OP_NONE; src = REG_SRC_ALU; vld = 1'b1; rdy = 1'b1;
        #1;
        for (int c = 0; c < 40; c++) begin
            chk($sformatf("addi c%0d pc_we", c), {31'd0, pc_we}, {31'd0, (c % 4) == 3});
            chk($sformatf("addi c%0d rf_we", c), {31'd0, rf_we}, {31'd0, (c % 4) == 3});
            tick();
        end
        chk("addi instret", instret_cnt, 32'd10);
        chk("addi cycle", cycle_cnt, 32'd41);

        // Illegal instruction: sticky trap, frozen cycle counter.
        reset_dut();
        vld = 1'b1; rdy = 1'b1;
        tick();
        vld = 1'b0;
        tick();
        chk("ill state", {29'd0, state}, {29'd0, S_TRAP});
        chk("ill trap", {31'd0, trap}, 32'd1);
        chk("ill cause", {30'd0, trap_cause}, {30'd0, TRAP_ILLEGAL});
        chk("ill strobes", {26'd0, mem_req, mem_we, mem_addr_sel, ir_we, rf_we, pc_we}, 32'd0);
        chk("ill cycle", cycle_cnt, 32'd3);
        repeat (20) begin
            rdy = ~rdy; vld = 1'b1;
            tick();
        end
        chk("ill cycle frozen", cycle_cnt, 32'd3);
        chk("ill still trap", {29'd0, state}, {29'd0, S_TRAP});
        chk("ill cause held", {30'd0, trap_cause}, {30'd0, TRAP_ILLEGAL});
        chk("ill req", {31'd0, mem_req}, 32'd0);
        rst = 1'b1;
        tick();
        chk("ill rst trap", {31'd0, trap}, 32'd0);
        chk("ill rst cause", {30'd0, trap_cause}, 32'd0);
        chk("ill rst state", {29'd0, state}, {29'd0, S_RESET});

        // Reset mid-transaction in S_MEM.
        reset_dut();
        op = MEM_OP_NONE; src = REG_SRC_ALU; vld = 1'b1; rdy = 1'b1;
        repeat (4) tick();
        op = MEM_OP_LOAD; src = REG_SRC_MEM;
        tick();
        tick();
        rdy = 1'b0;
        tick();
        chk("mrst pre state", {29'd0, state}, {29'd0, S_MEM});
        chk("mrst pre req", {31'd0, mem_req}, 32'd1);
        chk("mrst pre instret", instret_cnt, 32'd1);
        chk("mrst pre cycle", cycle_cnt, 32'd8);
        rst = 1'b1;
        tick();
        chk("mrst req", {31'd0, mem_req}, 32'd0);
        chk("mrst state", {29'd0, state}, {29'd0, S_RESET});
        chk("mrst cycle", cycle_cnt, 32'd0);
        chk("mrst instret", instret_cnt, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // Fetch never completes: trap after the 8th wait cycle.
        reset_dut();
        vld = 1'b1;
        repeat (7) tick();
        chk("to7 state", {29'd0, state}, {29'd0, S_FETCH});
        chk("to7 req", {31'd0, mem_req}, 32'd1);
        tick();
        chk("to state", {29'd0, state}, {29'd0, S_TRAP});
        chk("to cause", {30'd0, trap_cause}, {30'd0, TRAP_BUS});
        chk("to trap", {31'd0, trap}, 32'd1);
        // Completion in the limit cycle wins.
        reset_dut();
        vld = 1'b1;
        repeat (7) tick();
        rdy = 1'b1;
        #1;
        chk("tolim ir_we", {31'd0, ir_we}, 32'd1);
        tick();
        chk("tolim state", {29'd0, state}, {29'd0, S_DECODE});
        chk("tolim trap", {31'd0, trap}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
